pipelined_carry_increment_adder: RTL
====================================

# pipelined_carry_increment_adder

Parametrised, 3-stage pipelined carry-increment adder/subtractor with valid/ready flow control and status flags. Generalises the combinational carry-increment adder: width and block size are parameters, a carry-in and subtract mode are added, and the result is registered with backpressure. Sits between operand-issue logic and any registered consumer in the arithmetic datapath.

## Interface
- `N`, 64, operand/result width; must be a multiple of `BLOCK_SIZE`, with N/BLOCK_SIZE >= 2
- `BLOCK_SIZE`, 4, carry-increment block width; must be >= 2
- `clk`  in  1  sole clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  block accepts a beat this cycle
- `a`  in  N  operand A
- `b`  in  N  operand B
- `cin`  in  1  carry-in; used only when `op`=ADD
- `op`  in  1  0 = ADD (a+b+cin), 1 = SUB (a+~b+1)
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  consumer accepts result
- `sum`  out  N  result
- `cout`  out  1  carry out of bit N-1; for SUB, 1 = no borrow
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB
- `zero`  out  1  `sum` == 0

## Operation
- S0 (capture): on handshake, register `a`, effective B (`b` or `~b`), effective carry-in (`cin` for ADD, 1 for SUB), and per-bit g = a&B, p = a^B.
- S1 (block prefix): within each block, ripple-style prefix computes group (G,P) at every bit position relative to the block's LSB; bit 0 of block 0 folds in the carry-in. Registered.
- S2 (increment): carry into block k is C_k = G_{k-1} | (P_{k-1} & C_{k-1}), resolved serially across blocks; each bit's carry = local G | (local P & C_k). Compute sum = p ^ carries, `cout`, `ovf`, `zero`; register to outputs.
- Each stage holds a valid bit. Global advance `en` = !(out_valid && !out_ready). `in_ready` = `en`. When `en`=0 all stages hold; when `en`=1 every stage shifts forward and bubbles propagate.
- Width rules: no truncation inside; carries are N+1 bits wide internally; `cout` is bit N.

## Timing
- Latency 3 cycles from accepted beat to `out_valid` with `out_ready` held high; throughput 1 beat/cycle.
- Reset (any time, mid-operation included): all valid bits, `out_valid`, `sum`, `cout`, `ovf`, `zero` = 0 immediately; in-flight beats discarded. `in_ready` = 1 while reset deasserted and pipeline empty.
- `in_ready` depends combinationally on `out_valid`/`out_ready` only; never on `in_valid`.
- Output stable (sum, flags, `out_valid`) while `out_valid`=1 and `out_ready`=0.
- Simultaneous `in_valid` and output drain with full pipeline: both handshakes complete in the same cycle, no loss, no duplication.
- Bubble beats do not update output data registers when `out_valid` goes 0 (data don't-care, must not be X after reset).

## Structure
- Shared package `arith_pkg`: `OP_ADD`/`OP_SUB` constants, function `num_blocks(N, BLOCK_SIZE)`, elaboration check parameters.
- One sub-module, `cia_block_prefix`: `BLOCK_SIZE`-bit g/p in, block-relative G/P vectors out, instantiated N/BLOCK_SIZE times in S1 via generate.
- Elaboration-time error if N % BLOCK_SIZE != 0 or BLOCK_SIZE < 2.

## Test plan
- N=16, BS=4, ADD: a=0xFFFF, b=0x0001, cin=0 -> 3 cycles later sum=0x0000, cout=1, zero=1, ovf=0.
- N=16, SUB: a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1; SUB a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0.
- N=16, ADD a=0x00FF, b=0x0000, cin=1 -> sum=0x0100 (carry crosses two block boundaries), cout=0.
- Backpressure: stream 6 beats with `out_ready` low cycles 4-8 -> `in_ready` low those cycles, all 6 results delivered in order, none repeated, output held stable while stalled.
- Reset asserted with 3 beats in flight -> `out_valid`=0 same cycle; after release, a new beat 0x1234+0x1111 emerges as 0x2345 with no stale results.
- Default N=64, BS=4 and N=32, BS=8: 10k random ADD/SUB beats with random `out_ready` vs. reference model a+b+cin / a-b; sum, cout, ovf, zero all match.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic constants, block-count helper and parameter checks
package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int MIN_BLOCK_SIZE = 2;
  localparam int MIN_BLOCKS     = 2;

  function automatic int num_blocks(input int n, input int block_size);
    return n / block_size;
  endfunction

  function automatic bit params_ok(input int n, input int block_size);
    return (block_size >= MIN_BLOCK_SIZE) && ((n % block_size) == 0) &&
           ((n / block_size) >= MIN_BLOCKS);
  endfunction

endpackage

// File: rtl/cia_block_prefix.sv
// rtl/cia_block_prefix.sv - block-relative group generate/propagate prefix for one carry-increment block
module cia_block_prefix #(
  parameter int BLOCK_SIZE = 4
) (
  input  logic [BLOCK_SIZE-1:0] g,
  input  logic [BLOCK_SIZE-1:0] p,
  output logic [BLOCK_SIZE-1:0] grp_g,
  output logic [BLOCK_SIZE-1:0] grp_p
);

  always_comb begin
    grp_g    = '0;
    grp_p    = '0;
    grp_g[0] = g[0];
    grp_p[0] = p[0];
    for (int i = 1; i < BLOCK_SIZE; i++) begin
      grp_g[i] = g[i] | (p[i] & grp_g[i-1]);
      grp_p[i] = p[i] & grp_p[i-1];
    end
  end

endmodule

// File: rtl/pipelined_carry_increment_adder.sv
// rtl/pipelined_carry_increment_adder.sv - 3-stage carry-increment adder/subtractor with valid/ready and flags
module pipelined_carry_increment_adder
  import arith_pkg::*;
#(
  parameter int N          = 64,
  parameter int BLOCK_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NB = num_blocks(N, BLOCK_SIZE);

  generate
    if (!params_ok(N, BLOCK_SIZE)) begin : g_bad_params
      $error("pipelined_carry_increment_adder: N must be a multiple of BLOCK_SIZE >= 2 with at least 2 blocks");
    end
  endgenerate

  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // S0: capture effective operands as per-bit generate/propagate
  logic [N-1:0] b_eff;
  logic         cin_eff;
  assign b_eff   = (op == OP_SUB) ? ~b : b;
  assign cin_eff = (op == OP_SUB) ? 1'b1 : cin;

  logic         s0_valid, s0_cin;
  logic [N-1:0] s0_g, s0_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_cin   <= 1'b0;
      s0_g     <= '0;
      s0_p     <= '0;
    end else if (en) begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_g   <= a & b_eff;
        s0_p   <= a ^ b_eff;
        s0_cin <= cin_eff;
      end
    end
  end

  // S1: carry-in folded into bit 0 so block 0 needs no incoming carry later
  logic [N-1:0] g_fold, pre_g, pre_p;
  assign g_fold = {s0_g[N-1:1], s0_g[0] | (s0_p[0] & s0_cin)};

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cia_block_prefix #(.BLOCK_SIZE(BLOCK_SIZE)) u_prefix (
      .g     (g_fold[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .p     (s0_p[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .grp_g (pre_g[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .grp_p (pre_p[k*BLOCK_SIZE +: BLOCK_SIZE])
    );
  end

  logic         s1_valid, s1_cin;
  logic [N-1:0] s1_grp_g, s1_grp_p, s1_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cin   <= 1'b0;
      s1_grp_g <= '0;
      s1_grp_p <= '0;
      s1_p     <= '0;
    end else if (en) begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_cin   <= s0_cin;
        s1_grp_g <= pre_g;
        s1_grp_p <= pre_p;
        s1_p     <= s0_p;
      end
    end
  end

  // S2: block carry C_k equals the carry out of block k-1's top bit
  logic [N:0]   carry;
  logic [N-1:0] s2_sum;
  logic         blk_c;

  always_comb begin
    carry    = '0;
    blk_c    = 1'b0;
    carry[0] = s1_cin;
    for (int k = 0; k < NB; k++) begin
      blk_c = (k == 0) ? 1'b0 : carry[k*BLOCK_SIZE];
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        carry[k*BLOCK_SIZE+j+1] = s1_grp_g[k*BLOCK_SIZE+j] |
                                  (s1_grp_p[k*BLOCK_SIZE+j] & blk_c);
      end
    end
  end

  assign s2_sum = s1_p ^ carry[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= s2_sum;
        cout <= carry[N];
        ovf  <= carry[N] ^ carry[N-1];
        zero <= (s2_sum == '0);
      end
    end
  end

endmodule
